logic_event_counter: RTL and testbench
======================================

Name: logic_event_counter

Overview:
- Downstream consumer of the registered single-bit output of simple_logic_ff (its `out` flop).
- Detects rising edges on that bit and counts them over fixed windows of WINDOW enabled cycles.
- Hands each window's count to a downstream reader through a one-entry valid/ready output slot.
- Flags windows whose count saturated, and windows whose report was dropped.

Parameters:
- CNT_W, 8: width of the edge accumulator and of cnt_data.
- WINDOW, 16: enabled cycles per window; legal range is 2..65535.

Ports:
- clk  input  1  rising-edge clock, shared with simple_logic_ff.
- rst_n  input  1  asynchronous active-low reset.
- in_bit  input  1  monitored bit; already registered upstream, no synchroniser needed.
- enable  input  1  counting enable.
- clr  input  1  synchronous clear of window state.
- cnt_data  output  CNT_W  reported edge count of the window.
- cnt_sat  output  1  reported window hit saturation.
- cnt_valid  output  1  output slot full.
- cnt_ready  input  1  downstream accept.
- overflow  output  1  sticky: at least one report was dropped.

Behaviour:
- Reset (async assert, sync release): all outputs are 0. Internal state after reset:
  - accumulator = 0, window counter = 0, sat flag = 0.
  - prev_bit = 1, so in_bit already high out of reset is not counted as an edge.
- Edge detect:
  - edge = in_bit & ~prev_bit.
  - prev_bit <= in_bit on every clock, regardless of enable or clr, so re-enabling causes no spurious edge.
- Enable:
  - enable=0: window counter, accumulator and sat hold; edges are ignored.
  - enable=1: window counter increments from 0 to WINDOW-1, then wraps to 0.
- Accumulator:
  - acc_next = acc + edge, saturating at 2^CNT_W-1.
  - Saturation also sets the window's sat flag.
- Window end (enable=1 and window counter == WINDOW-1):
  - final = acc_next, i.e. an edge in the last cycle is included.
  - The slot is loaded if it is empty, or if it is full with cnt_ready=1 in the same cycle (drain and refill together, no bubble).
  - On load: cnt_data <= final, cnt_sat <= sat_next, cnt_valid <= 1 from the next cycle.
  - If the slot is full and cnt_ready=0: the report is dropped, overflow <= 1, and slot contents are unchanged.
  - In either case the accumulator and sat reset to 0 for the new window.
- Output handshake:
  - Transfer occurs when cnt_valid & cnt_ready. With no refill that cycle, cnt_valid <= 0.
  - cnt_data and cnt_sat are stable while cnt_valid=1 and cnt_ready=0.
  - cnt_ready while cnt_valid=0 has no effect.
- clr:
  - Zeroes the accumulator, window counter, sat and overflow.
  - Does not touch the output slot or prev_bit.
  - clr coinciding with window end: clr wins, no report is loaded and overflow is not set. A handshake transfer in that same cycle still completes.
- Latency: report for a window is visible (cnt_valid=1) exactly one cycle after that window's last counted clock edge.
- Reset mid-window or with the slot full: all state returns to reset values and any pending report is lost.
- Implementation: two counters, edge detector, one-entry slot; roughly 150 lines of RTL.

Test Plan:
- Reset with in_bit=1, then enable=1 and in_bit held at 1 for 16 cycles -> one report, cnt_data=0, cnt_sat=0, cnt_valid high on cycle 17.
- in_bit toggling 0/1 every cycle, WINDOW=16, cnt_ready=1 -> cnt_data=8 every 16 cycles, no gaps, overflow=0.
- cnt_ready=0 across two window ends -> first count held stable, second count dropped, overflow=1 and sticky; clr pulse -> overflow=0 with slot intact.
- CNT_W=3 with 10 edges in one window -> cnt_data=7, cnt_sat=1; next window with 2 edges -> cnt_data=2, cnt_sat=0.
- enable deasserted for 5 cycles mid-window with in_bit toggling -> edges in the gap are ignored; window end is delayed by 5 cycles.
- clr asserted on the window-end cycle while the slot is draining -> old report transfers, no new report, window restarts from 0; rst_n pulsed mid-window -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/logic_event_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_event_counter: rising-edge counter over WINDOW enabled cycles with  |
// | a one-entry valid/ready report slot and sticky drop flag.                 |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+

module logic_event_counter #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             enable,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_sat,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overflow
);

  localparam int                 c_win_w    = $clog2(WINDOW);
  localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW - 1);
  localparam logic [CNT_W-1:0]   c_acc_max  = '1;

  logic               r_prev;
  logic [CNT_W-1:0]   r_acc;
  logic               r_sat;
  logic [c_win_w-1:0] r_win;

  logic               w_edge;
  logic [CNT_W-1:0]   w_acc_next;
  logic               w_sat_next;
  logic               w_win_last;
  logic               w_win_end;
  logic               w_xfer;
  logic               w_load;
  logic               w_drop;

  // prev_bit resets high so a level already high out of reset is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= in_bit;
    end
  end

  assign w_edge     = in_bit & ~r_prev;
  assign w_acc_next = (w_edge && (r_acc != c_acc_max)) ? r_acc + CNT_W'(1) : r_acc;
  assign w_sat_next = r_sat | (w_edge & (w_acc_next == c_acc_max));

  assign w_win_last = (r_win == c_win_last);
  assign w_win_end  = enable & ~clr & w_win_last;
  assign w_xfer     = cnt_valid & cnt_ready;
  assign w_load     = w_win_end & (~cnt_valid | cnt_ready);
  assign w_drop     = w_win_end & cnt_valid & ~cnt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_sat    <= 1'b0;
      r_win    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      r_acc    <= '0;
      r_sat    <= 1'b0;
      r_win    <= '0;
      overflow <= 1'b0;
    end else if (enable) begin
      if (w_win_last) begin
        r_acc <= '0;
        r_sat <= 1'b0;
        r_win <= '0;
      end else begin
        r_acc <= w_acc_next;
        r_sat <= w_sat_next;
        r_win <= r_win + c_win_w'(1);
      end
      if (w_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Refill takes priority over drain so a full slot can hand off and reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_data  <= '0;
      cnt_sat   <= 1'b0;
      cnt_valid <= 1'b0;
    end else if (w_load) begin
      cnt_data  <= w_acc_next;
      cnt_sat   <= w_sat_next;
      cnt_valid <= 1'b1;
    end else if (w_xfer) begin
      cnt_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_logic_event_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_logic_event_counter: directed bench with a window/edge-count model    |
// | for two counter configurations (8-bit/16-cycle and 3-bit/24-cycle).      |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+

module tb_logic_event_counter;

  localparam int WIN [2] = '{16, 24};
  localparam int MXV [2] = '{255, 7};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_bit;
  logic       enable;
  logic       clr;
  logic       cnt_ready;
  logic [7:0] data8;
  logic       sat8, valid8, ovf8;
  logic [2:0] data3;
  logic       sat3, valid3, ovf3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_event_counter #(.CNT_W(8), .WINDOW(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .enable(enable), .clr(clr),
    .cnt_data(data8), .cnt_sat(sat8), .cnt_valid(valid8), .cnt_ready(cnt_ready),
    .overflow(ovf8)
  );

  logic_event_counter #(.CNT_W(3), .WINDOW(24)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .enable(enable), .clr(clr),
    .cnt_data(data3), .cnt_sat(sat3), .cnt_valid(valid3), .cnt_ready(cnt_ready),
    .overflow(ovf3)
  );

  // Model: count enabled cycles and true (unclipped) edges; clip only at report time
  typedef struct {
    int cyc;
    int edges;
    int data;
    bit sat;
    bit valid;
    bit ovf;
  } mstate_t;

  mstate_t m [2];
  bit      m_prev;

  function automatic mstate_t mstep(input mstate_t s, input int k, input bit e);
    mstate_t n = s;
    bit load = 0;
    if (clr) begin
      n.cyc = 0;
      n.edges = 0;
      n.ovf = 0;
    end else if (enable) begin
      n.edges = n.edges + (e ? 1 : 0);
      if (n.cyc == WIN[k] - 1) begin
        if (!s.valid || cnt_ready) begin
          load = 1;
          n.data = (n.edges > MXV[k]) ? MXV[k] : n.edges;
          n.sat = (n.edges >= MXV[k]);
        end else begin
          n.ovf = 1;
        end
        n.cyc = 0;
        n.edges = 0;
      end else begin
        n.cyc = n.cyc + 1;
      end
    end
    if (load) n.valid = 1;
    else if (s.valid && cnt_ready) n.valid = 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev <= 1'b1;
      m[0] <= '{default: 0};
      m[1] <= '{default: 0};
    end else begin
      m_prev <= in_bit;
      m[0] <= mstep(m[0], 0, in_bit & ~m_prev);
      m[1] <= mstep(m[1], 1, in_bit & ~m_prev);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("m8.data", int'(data8), m[0].data);
    chk("m8.sat", int'(sat8), int'(m[0].sat));
    chk("m8.valid", int'(valid8), int'(m[0].valid));
    chk("m8.ovf", int'(ovf8), int'(m[0].ovf));
    chk("m3.data", int'(data3), m[1].data);
    chk("m3.sat", int'(sat3), int'(m[1].sat));
    chk("m3.valid", int'(valid3), int'(m[1].valid));
    chk("m3.ovf", int'(ovf3), int'(m[1].ovf));
  end

  task automatic cyc(input logic b, input logic e, input logic c, input logic r);
    in_bit = b;
    enable = e;
    clr = c;
    cnt_ready = r;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_bit = 1'b1;
    enable = 1'b0;
    clr = 1'b0;
    cnt_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.valid8", int'(valid8), 0);
    chk("reset.data8", int'(data8), 0);
    chk("reset.ovf8", int'(ovf8), 0);
    rst_n = 1'b1;

    // Level high from reset: one report of zero on cycle 17
    for (int i = 0; i < 15; i++) cyc(1, 1, 0, 0);
    chk("hold1.valid_early", int'(valid8), 0);
    cyc(1, 1, 0, 0);
    chk("hold1.valid", int'(valid8), 1);
    chk("hold1.data", int'(data8), 0);
    chk("hold1.sat", int'(sat8), 0);
    cyc(1, 0, 0, 1);
    chk("hold1.drained", int'(valid8), 0);

    // Toggling every cycle: 8 edges per window, back-to-back reports
    for (int i = 0; i < 48; i++) begin
      cyc(logic'(i % 2), 1, 0, 1);
      if (i % 16 == 15) begin
        chk("toggle.valid", int'(valid8), 1);
        chk("toggle.data", int'(data8), 8);
        chk("toggle.ovf", int'(ovf8), 0);
      end
    end

    // Back-pressure across two window ends: second report dropped
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(logic'(i % 2), 1, 0, 0);
    chk("bp.first_data", int'(data8), 8);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0);
    chk("bp.held_data", int'(data8), 8);
    chk("bp.held_valid", int'(valid8), 1);
    chk("bp.ovf", int'(ovf8), 1);
    cyc(0, 0, 0, 0);
    chk("bp.ovf_sticky", int'(ovf8), 1);
    cyc(0, 0, 1, 0);
    chk("clr.ovf", int'(ovf8), 0);
    chk("clr.slot_valid", int'(valid8), 1);
    chk("clr.slot_data", int'(data8), 8);
    cyc(0, 0, 0, 1);

    // 3-bit counter: 10 edges saturate at 7, then a 2-edge window
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 24; i++) cyc((i < 20) ? logic'(i % 2) : 1'b0, 1, 0, 1);
    chk("sat.valid3", int'(valid3), 1);
    chk("sat.data3", int'(data3), 7);
    chk("sat.sat3", int'(sat3), 1);
    for (int i = 0; i < 24; i++) cyc((i == 1 || i == 3) ? 1'b1 : 1'b0, 1, 0, 1);
    chk("nosat.valid3", int'(valid3), 1);
    chk("nosat.data3", int'(data3), 2);
    chk("nosat.sat3", int'(sat3), 0);

    // Enable gap of 5 cycles: gap edges ignored, window end delayed
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 21; i++) begin
      cyc(logic'(i % 2), (i >= 8 && i < 13) ? 1'b0 : 1'b1, 0, 1);
      if (i == 19) chk("gap.not_yet", int'(valid8), 0);
    end
    chk("gap.valid", int'(valid8), 1);
    chk("gap.data", int'(data8), 8);

    // clr on window end while the slot drains
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 16; i++) cyc(logic'(i % 2), 1, 0, 0);
    chk("clrend.loaded", int'(valid8), 1);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 1);
    chk("clrend.valid", int'(valid8), 0);
    chk("clrend.ovf", int'(ovf8), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(logic'(i % 2), 1, 0, 1);
      if (i == 14) chk("clrend.restart_early", int'(valid8), 0);
    end
    chk("clrend.restart_valid", int'(valid8), 1);
    chk("clrend.restart_data", int'(data8), 8);

    // Async reset mid-window with the slot full and overflow set
    for (int i = 0; i < 21; i++) cyc(logic'(i % 2), 1, 0, 0);
    chk("prerst.valid", int'(valid8), 1);
    chk("prerst.ovf", int'(ovf8), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.data8", int'(data8), 0);
    chk("arst.sat8", int'(sat8), 0);
    chk("arst.valid8", int'(valid8), 0);
    chk("arst.ovf8", int'(ovf8), 0);
    chk("arst.valid3", int'(valid3), 0);
    @(negedge clk);
    cyc(1, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 1);
    chk("postrst.valid", int'(valid8), 1);
    chk("postrst.data", int'(data8), 0);
    cyc(1, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
